// File: rtl/sram_arbiter.sv
// Two-requester arbiter in front of a single-port SRAM with registered read data.
// Round-robin on contention, one transaction in flight, write-protect window at wp_base and above.
module sram_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_req,
    input  logic       a_we,
    input  logic [5:0] a_addr,
    input  logic [7:0] a_wdata,
    output logic       a_ack,
    output logic       a_err,
    output logic [7:0] a_rdata,
    input  logic       b_req,
    input  logic       b_we,
    input  logic [5:0] b_addr,
    input  logic [7:0] b_wdata,
    output logic       b_ack,
    output logic       b_err,
    output logic [7:0] b_rdata,
    input  logic       wp_en,
    input  logic [5:0] wp_base,
    output logic [5:0] mem_addr,
    output logic [7:0] mem_din,
    output logic       mem_wren,
    input  logic [7:0] mem_dout,
    output logic       busy,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic       r_last_grant;  // 1 = B was granted last
    logic       r_owner;       // 1 = B owns the transaction in flight
    logic       r_we;
    logic       r_reject;
    logic [1:0] r_wait_cnt;
    logic [5:0] r_mem_addr;
    logic [7:0] r_mem_din;
    logic       r_mem_wren;
    logic       r_a_ack;
    logic       r_a_err;
    logic [7:0] r_a_rdata;
    logic       r_b_ack;
    logic       r_b_err;
    logic [7:0] r_b_rdata;

    logic       w_a_elig;
    logic       w_b_elig;
    logic       w_grant;
    logic       w_grant_b;
    logic       w_sel_we;
    logic [5:0] w_sel_addr;
    logic [7:0] w_sel_wdata;
    logic       w_reject;

    // Handshake: a requester holds req (and we/addr/wdata stable) until it sees a
    // one-cycle ack; a requester whose ack is high this cycle is not eligible, so a
    // req still held during the ack cycle is never serviced twice.
    always_comb begin
        w_a_elig     = a_req & ~r_a_ack;
        w_b_elig     = b_req & ~r_b_ack;
        w_grant      = 1'b0;
        w_grant_b    = 1'b0;
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_a_elig || w_b_elig) begin
                    w_grant      = 1'b1;
                    w_grant_b    = w_b_elig & (~w_a_elig | ~r_last_grant);
                    w_next_state = ISSUE;
                end
            end
            ISSUE:   w_next_state = r_we ? IDLE : RDWAIT;
            RDWAIT:  w_next_state = (r_wait_cnt == 2'd0) ? IDLE : RDWAIT;
            default: w_next_state = IDLE;
        endcase
        w_sel_we    = w_grant_b ? b_we    : a_we;
        w_sel_addr  = w_grant_b ? b_addr  : a_addr;
        w_sel_wdata = w_grant_b ? b_wdata : a_wdata;
        w_reject    = w_sel_we & wp_en & (w_sel_addr >= wp_base);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_we         <= 1'b0;
            r_reject     <= 1'b0;
            r_wait_cnt   <= 2'd0;
            r_mem_addr   <= 6'd0;
            r_mem_din    <= 8'd0;
            r_mem_wren   <= 1'b0;
            r_a_ack      <= 1'b0;
            r_a_err      <= 1'b0;
            r_a_rdata    <= 8'd0;
            r_b_ack      <= 1'b0;
            r_b_err      <= 1'b0;
            r_b_rdata    <= 8'd0;
        end else begin
            r_mem_wren <= 1'b0;
            r_a_ack    <= 1'b0;
            r_a_err    <= 1'b0;
            r_b_ack    <= 1'b0;
            r_b_err    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_owner      <= w_grant_b;
                        r_last_grant <= w_grant_b;
                        r_we         <= w_sel_we;
                        r_reject     <= w_reject;
                        r_mem_addr   <= w_sel_addr;
                        r_mem_din    <= w_sel_wdata;
                        r_mem_wren   <= w_sel_we & ~w_reject;
                    end
                end
                ISSUE: begin
                    if (r_we) begin
                        // A rejected write still completes with the normal write timing.
                        if (r_owner) begin
                            r_b_ack <= 1'b1;
                            r_b_err <= r_reject;
                        end else begin
                            r_a_ack <= 1'b1;
                            r_a_err <= r_reject;
                        end
                    end else begin
                        r_wait_cnt <= 2'(RD_LAT - 1);
                    end
                end
                RDWAIT: begin
                    if (r_wait_cnt == 2'd0) begin
                        if (r_owner) begin
                            r_b_ack   <= 1'b1;
                            r_b_rdata <= mem_dout;
                        end else begin
                            r_a_ack   <= 1'b1;
                            r_a_rdata <= mem_dout;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_din   = r_mem_din;
    assign mem_wren  = r_mem_wren;
    assign a_ack     = r_a_ack;
    assign a_err     = r_a_err;
    assign a_rdata   = r_a_rdata;
    assign b_ack     = r_b_ack;
    assign b_err     = r_b_err;
    assign b_rdata   = r_b_rdata;
    assign busy      = (r_state != IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: RD_LAT=1 instance with a behavioural SRAM and scoreboard,
// plus an RD_LAT=3 instance for long-latency read and mid-read reset scenarios.
`timescale 1ns/1ps
module tb_sram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    always #5 clk = ~clk;

    logic       a_req, a_we, a_ack, a_err;
    logic [5:0] a_addr;
    logic [7:0] a_wdata, a_rdata;
    logic       b_req, b_we, b_ack, b_err;
    logic [5:0] b_addr;
    logic [7:0] b_wdata, b_rdata;
    logic       wp_en;
    logic [5:0] wp_base;
    logic [5:0] mem_addr;
    logic [7:0] mem_din, mem_dout;
    logic       mem_wren, busy;
    logic [1:0] dbg_state;

    logic       l3_a_req, l3_a_we, l3_a_ack, l3_a_err;
    logic [5:0] l3_a_addr;
    logic [7:0] l3_a_wdata, l3_a_rdata;
    logic       l3_b_req, l3_b_we, l3_b_ack, l3_b_err;
    logic [5:0] l3_b_addr;
    logic [7:0] l3_b_wdata, l3_b_rdata;
    logic [5:0] l3_mem_addr;
    logic [7:0] l3_mem_din, l3_mem_dout;
    logic       l3_mem_wren, l3_busy;
    logic [1:0] l3_dbg_state;

    sram_arbiter #(.RD_LAT(1)) u_dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
        .wp_en(wp_en), .wp_base(wp_base),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_wren(mem_wren), .mem_dout(mem_dout),
        .busy(busy), .dbg_state(dbg_state)
    );

    sram_arbiter #(.RD_LAT(3)) u_dut_l3 (
        .clk(clk), .rst(rst),
        .a_req(l3_a_req), .a_we(l3_a_we), .a_addr(l3_a_addr), .a_wdata(l3_a_wdata),
        .a_ack(l3_a_ack), .a_err(l3_a_err), .a_rdata(l3_a_rdata),
        .b_req(l3_b_req), .b_we(l3_b_we), .b_addr(l3_b_addr), .b_wdata(l3_b_wdata),
        .b_ack(l3_b_ack), .b_err(l3_b_err), .b_rdata(l3_b_rdata),
        .wp_en(wp_en), .wp_base(wp_base),
        .mem_addr(l3_mem_addr), .mem_din(l3_mem_din), .mem_wren(l3_mem_wren), .mem_dout(l3_mem_dout),
        .busy(l3_busy), .dbg_state(l3_dbg_state)
    );

    // SRAM behind the RD_LAT=1 instance: one registered read stage.
    logic [7:0] sram [64];
    always @(posedge clk) begin
        if (mem_wren) sram[mem_addr] <= mem_din;
        mem_dout <= sram[mem_addr];
    end

    // Read-only SRAM behind the RD_LAT=3 instance, contents a fixed function of address.
    function automatic logic [7:0] l3_pat(input logic [5:0] a);
        return {a, 2'b01} ^ 8'hA6;
    endfunction

    logic [7:0] l3_pipe [3];
    always @(posedge clk) begin
        l3_pipe[0] <= l3_pat(l3_mem_addr);
        l3_pipe[1] <= l3_pipe[0];
        l3_pipe[2] <= l3_pipe[1];
    end
    assign l3_mem_dout = l3_pipe[2];

    // Scoreboard state
    int          vectors = 0;
    int          miscompares = 0;
    int          wren_count = 0;
    int          a_acks = 0;
    logic [8:0]  exp_a_q[$];
    logic [8:0]  exp_b_q[$];
    logic [13:0] exp_wr_q[$];
    logic        ack_log[$];
    logic [7:0]  ref_mem [64];
    logic [7:0]  last_rd [2];
    logic [8:0]  mon_a, mon_b;
    logic [13:0] mon_wr;

    always @(negedge clk) begin
        if (a_ack || b_ack) begin
            vectors++;
            if (a_ack && b_ack) begin
                miscompares++;
                $display("FAIL ack_overlap got a_ack=%b b_ack=%b want at most one", a_ack, b_ack);
            end
        end
        if (a_ack) begin
            a_acks++;
            ack_log.push_back(1'b0);
            vectors++;
            if (exp_a_q.size() == 0) begin
                miscompares++;
                $display("FAIL a_ack_unexpected got ack err=%b rdata=%h want no ack", a_err, a_rdata);
            end else begin
                mon_a = exp_a_q.pop_front();
                if ({a_err, a_rdata} !== mon_a) begin
                    miscompares++;
                    $display("FAIL a_ack_result got err=%b rdata=%h want err=%b rdata=%h",
                             a_err, a_rdata, mon_a[8], mon_a[7:0]);
                end
            end
        end
        if (b_ack) begin
            ack_log.push_back(1'b1);
            vectors++;
            if (exp_b_q.size() == 0) begin
                miscompares++;
                $display("FAIL b_ack_unexpected got ack err=%b rdata=%h want no ack", b_err, b_rdata);
            end else begin
                mon_b = exp_b_q.pop_front();
                if ({b_err, b_rdata} !== mon_b) begin
                    miscompares++;
                    $display("FAIL b_ack_result got err=%b rdata=%h want err=%b rdata=%h",
                             b_err, b_rdata, mon_b[8], mon_b[7:0]);
                end
            end
        end
        if (mem_wren) begin
            wren_count++;
            vectors++;
            if (exp_wr_q.size() == 0) begin
                miscompares++;
                $display("FAIL wren_unexpected got addr=%h din=%h want no write", mem_addr, mem_din);
            end else begin
                mon_wr = exp_wr_q.pop_front();
                if ({mem_addr, mem_din} !== mon_wr) begin
                    miscompares++;
                    $display("FAIL wren_data got addr=%h din=%h want addr=%h din=%h",
                             mem_addr, mem_din, mon_wr[13:8], mon_wr[7:0]);
                end
            end
        end
    end

    // Driver: pushes expectations, holds req through the ack cycle, drops it the cycle after.
    // Entered and left at posedge+1.
    task automatic access(input logic who, input logic we, input logic [5:0] addr,
                          input logic [7:0] wd, output int lat, output int nbusy);
        logic rej;
        rej = we && wp_en && (addr >= wp_base);
        if (!we) last_rd[who] = ref_mem[addr];
        if (we && !rej) begin
            ref_mem[addr] = wd;
            exp_wr_q.push_back({addr, wd});
        end
        if (who) begin
            exp_b_q.push_back({rej, last_rd[1]});
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
        end else begin
            exp_a_q.push_back({rej, last_rd[0]});
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
        end
        lat = -1;
        nbusy = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if ((who ? b_ack : a_ack) === 1'b1) begin
                lat = n - 1;
                break;
            end
            if (busy) nbusy++;
        end
        if (lat < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_ack_timeout got no ack want ack within 40 cycles", who ? "b" : "a");
            if (who && exp_b_q.size() > 0) void'(exp_b_q.pop_back());
            if (!who && exp_a_q.size() > 0) void'(exp_a_q.pop_back());
        end
        @(posedge clk);
        #1;
        if (who) b_req = 1'b0;
        else a_req = 1'b0;
    endtask

    task automatic l3_read(input logic [5:0] addr, output int lat, output int nbusy);
        l3_a_req = 1'b1; l3_a_we = 1'b0; l3_a_addr = addr;
        lat = -1;
        nbusy = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (l3_a_ack === 1'b1) begin
                lat = n - 1;
                break;
            end
            if (l3_busy) nbusy++;
        end
        @(posedge clk);
        #1;
        l3_a_req = 1'b0;
    endtask

    task automatic test_reset();
        int k0;
        @(negedge clk);
        vectors++;
        if ({busy, a_ack, a_err, b_ack, b_err, mem_wren, mem_addr, mem_din, a_rdata, b_rdata, dbg_state} !== 45'd0) begin
            miscompares++;
            $display("FAIL reset_values got busy=%b acks=%b%b wren=%b addr=%h din=%h want all zero",
                     busy, a_ack, b_ack, mem_wren, mem_addr, mem_din);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        a_req = 1'b1; a_we = 1'b1; a_addr = 6'd7; a_wdata = 8'h9A;
        exp_wr_q.push_back({6'd7, 8'h9A});
        k0 = a_acks;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({busy, mem_wren, mem_addr} !== {1'b1, 1'b1, 6'd7}) begin
            miscompares++;
            $display("FAIL issue_state got busy=%b wren=%b addr=%h want busy=1 wren=1 addr=07",
                     busy, mem_wren, mem_addr);
        end
        a_req = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy, mem_wren, mem_addr, mem_din, a_ack, a_err, dbg_state} !== 19'd0) begin
            miscompares++;
            $display("FAIL async_reset got busy=%b wren=%b addr=%h din=%h ack=%b want all zero",
                     busy, mem_wren, mem_addr, mem_din, a_ack);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (a_acks != k0) begin
            miscompares++;
            $display("FAIL abandoned_ack got %0d acks want 0", a_acks - k0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        int lat, nb, w0;
        @(posedge clk);
        #1;
        w0 = wren_count;
        access(1'b0, 1'b1, 6'd5, 8'h3C, lat, nb);
        vectors++;
        if (lat != 2) begin miscompares++; $display("FAIL write_latency got %0d want 2", lat); end
        vectors++;
        if (nb != 1) begin miscompares++; $display("FAIL write_busy got %0d want 1", nb); end
        access(1'b0, 1'b0, 6'd5, 8'h00, lat, nb);
        vectors++;
        if (lat != 3) begin miscompares++; $display("FAIL read_latency got %0d want 3", lat); end
        vectors++;
        if (nb != 2) begin miscompares++; $display("FAIL read_busy got %0d want 2", nb); end
        vectors++;
        if (a_rdata !== 8'h3C) begin miscompares++; $display("FAIL a_rdata_hold got %h want 3c", a_rdata); end
        vectors++;
        if (wren_count - w0 != 1) begin
            miscompares++; $display("FAIL write_pulses got %0d want 1", wren_count - w0);
        end
    endtask

    task automatic test_write_protect();
        int lat, nb, w0;
        @(posedge clk);
        #1;
        wp_en = 1'b1;
        wp_base = 6'h30;
        w0 = wren_count;
        access(1'b1, 1'b1, 6'h30, 8'h11, lat, nb);
        vectors++;
        if (wren_count != w0 || lat != 2) begin
            miscompares++;
            $display("FAIL wp_reject got pulses=%0d lat=%0d want pulses=0 lat=2", wren_count - w0, lat);
        end
        w0 = wren_count;
        access(1'b1, 1'b1, 6'h2F, 8'hD2, lat, nb);
        vectors++;
        if (wren_count - w0 != 1) begin
            miscompares++; $display("FAIL wp_below_base got pulses=%0d want 1", wren_count - w0);
        end
        access(1'b1, 1'b0, 6'h2F, 8'h00, lat, nb);
        vectors++;
        if (b_rdata !== 8'hD2) begin miscompares++; $display("FAIL b_read_back got %h want d2", b_rdata); end
        wp_base = 6'h00;
        w0 = wren_count;
        access(1'b1, 1'b1, 6'h00, 8'h55, lat, nb);
        vectors++;
        if (wren_count != w0) begin
            miscompares++; $display("FAIL wp_base_zero got pulses=%0d want 0", wren_count - w0);
        end
        access(1'b1, 1'b0, 6'h05, 8'h00, lat, nb);
        vectors++;
        if (b_rdata !== 8'h3C) begin miscompares++; $display("FAIL read_under_wp got %h want 3c", b_rdata); end
        wp_en = 1'b0;
    endtask

    task automatic test_contention();
        int la, ba, lb, bb;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        ack_log.delete();
        fork
            begin
                access(1'b0, 1'b1, 6'd10, 8'h81, la, ba);
                access(1'b0, 1'b1, 6'd11, 8'h82, la, ba);
                access(1'b0, 1'b1, 6'd12, 8'h83, la, ba);
            end
            begin
                access(1'b1, 1'b0, 6'd5, 8'h00, lb, bb);
                access(1'b1, 1'b0, 6'h2F, 8'h00, lb, bb);
                access(1'b1, 1'b0, 6'd5, 8'h00, lb, bb);
            end
        join
        vectors++;
        if (ack_log.size() != 6) begin
            miscompares++; $display("FAIL grant_count got %0d want 6", ack_log.size());
        end
        for (int i = 0; i < ack_log.size() && i < 6; i++) begin
            vectors++;
            if (ack_log[i] !== 1'(i % 2)) begin
                miscompares++;
                $display("FAIL grant_order[%0d] got %s want %s", i, ack_log[i] ? "B" : "A", (i % 2) ? "B" : "A");
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, nb, w0, k0;
        @(posedge clk);
        #1;
        w0 = wren_count;
        k0 = a_acks;
        access(1'b0, 1'b1, 6'd20, 8'h77, lat, nb);
        repeat (6) @(negedge clk);
        vectors++;
        if (wren_count - w0 != 1) begin
            miscompares++; $display("FAIL b2b_wren got %0d want 1", wren_count - w0);
        end
        vectors++;
        if (a_acks - k0 != 1) begin
            miscompares++; $display("FAIL b2b_acks got %0d want 1", a_acks - k0);
        end
    endtask

    task automatic test_rd_lat3();
        int lat, nb;
        @(posedge clk);
        #1;
        l3_read(6'd9, lat, nb);
        vectors++;
        if (lat != 5) begin miscompares++; $display("FAIL l3_latency got %0d want 5", lat); end
        vectors++;
        if (nb != 4) begin miscompares++; $display("FAIL l3_busy got %0d want 4", nb); end
        vectors++;
        if (l3_a_rdata !== l3_pat(6'd9)) begin
            miscompares++; $display("FAIL l3_rdata got %h want %h", l3_a_rdata, l3_pat(6'd9));
        end
        vectors++;
        if (l3_a_ack !== 1'b0) begin miscompares++; $display("FAIL l3_ack_pulse got %b want 0", l3_a_ack); end
    endtask

    task automatic test_reset_mid();
        int lat, nb;
        logic seen_state, seen_ack;
        @(posedge clk);
        #1;
        l3_a_req = 1'b1; l3_a_we = 1'b0; l3_a_addr = 6'd17;
        seen_state = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (l3_dbg_state == 2'd2) begin
                seen_state = 1'b1;
                break;
            end
        end
        vectors++;
        if (!seen_state) begin miscompares++; $display("FAIL l3_rdwait got no RDWAIT want RDWAIT"); end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({l3_busy, l3_a_ack, l3_a_err, l3_a_rdata, l3_mem_addr, l3_mem_din, l3_mem_wren,
             l3_b_ack, l3_b_err, l3_b_rdata, l3_dbg_state} !== 45'd0) begin
            miscompares++;
            $display("FAIL l3_async_reset got busy=%b ack=%b rdata=%h addr=%h want all zero",
                     l3_busy, l3_a_ack, l3_a_rdata, l3_mem_addr);
        end
        l3_a_req = 1'b0;
        seen_ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (l3_a_ack) seen_ack = 1'b1;
        end
        vectors++;
        if (seen_ack) begin miscompares++; $display("FAIL l3_abandoned_ack got ack want none"); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        l3_read(6'd17, lat, nb);
        vectors++;
        if (lat != 5 || l3_a_rdata !== l3_pat(6'd17)) begin
            miscompares++;
            $display("FAIL l3_reissue got lat=%0d rdata=%h want lat=5 rdata=%h", lat, l3_a_rdata, l3_pat(6'd17));
        end
    endtask

    initial begin
        rst = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = 6'd0; a_wdata = 8'd0;
        b_req = 1'b0; b_we = 1'b0; b_addr = 6'd0; b_wdata = 8'd0;
        wp_en = 1'b0; wp_base = 6'd0;
        l3_a_req = 1'b0; l3_a_we = 1'b0; l3_a_addr = 6'd0; l3_a_wdata = 8'd0;
        l3_b_req = 1'b0; l3_b_we = 1'b0; l3_b_addr = 6'd0; l3_b_wdata = 8'd0;
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        test_reset();
        test_write_read();
        test_write_protect();
        test_contention();
        test_back_to_back();
        test_rd_lat3();
        test_reset_mid();
        repeat (2) @(negedge clk);
        vectors++;
        if (exp_a_q.size() + exp_b_q.size() + exp_wr_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got a=%0d b=%0d wr=%0d pending want 0",
                     exp_a_q.size(), exp_b_q.size(), exp_wr_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
